// File: rtl/mux_scan_if.sv
// Frame delivery channel from the scan controller to its consumer.
// The controller drives frame and frame_valid, and the consumer drives frame_ready.
interface mux_scan_if #(
  parameter int unsigned DATA_WIDTH = 3
);
  logic [5*DATA_WIDTH-1:0] frame;
  logic                    frame_valid;
  logic                    frame_ready;

  modport master (output frame, output frame_valid, input frame_ready);
  modport slave  (input frame, input frame_valid, output frame_ready);
endinterface

// File: rtl/mux_scan_ctrl.sv
// Steps the 5:1 mux select through channels 0..4 and holds each one for DWELL cycles.
// It captures the mux output into a 5-slot frame and offers the frame over valid/ready.
module mux_scan_ctrl #(
  parameter int unsigned DATA_WIDTH = 3,
  parameter int unsigned DWELL      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  continuous_i,
  input  logic [DATA_WIDTH-1:0] m_i,
  output logic [2:0]            s_o,
  output logic                  busy_o,
  output logic                  overrun_o,
  mux_scan_if.master            bus
);

  localparam int unsigned CNT_W   = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int unsigned BUF_W   = 4 * DATA_WIDTH;
  localparam int unsigned FRAME_W = 5 * DATA_WIDTH;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DWELL - 1);
  localparam logic [2:0]       LAST_CH    = 3'd4;

  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [2:0]           s_q, s_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BUF_W-1:0]     buf_q, buf_d;
  logic [FRAME_W-1:0]   frame_q, frame_d;
  logic                 valid_q, valid_d;
  logic                 overrun_q, overrun_d;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      s_q       <= 3'd0;
      cnt_q     <= '0;
      buf_q     <= '0;
      frame_q   <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      cnt_q     <= cnt_d;
      buf_q     <= buf_d;
      frame_q   <= frame_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  // Next-state: dwell countdown, slot capture, frame hand-off
  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    cnt_d     = cnt_q;
    buf_d     = buf_q;
    frame_d   = frame_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;

    if (valid_q && bus.frame_ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        s_d = 3'd0;
        if (start_i) begin
          state_d = SCAN;
          cnt_d   = CNT_RELOAD;
        end
      end
      SCAN: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (s_q < LAST_CH) begin
          buf_d[int'(s_q)*DATA_WIDTH +: DATA_WIDTH] = m_i;
          s_d   = s_q + 3'd1;
          cnt_d = CNT_RELOAD;
        end else begin
          // Slot 4 goes straight into the frame; a completion can also be the accept edge
          if (!valid_q || bus.frame_ready) begin
            frame_d = {m_i, buf_q};
            valid_d = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
          s_d = 3'd0;
          if (continuous_i) begin
            cnt_d = CNT_RELOAD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign s_o             = s_q;
  assign busy_o          = (state_q == SCAN);
  assign overrun_o       = overrun_q;
  assign bus.frame       = frame_q;
  assign bus.frame_valid = valid_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed and randomized checks of mux_scan_ctrl at DWELL=4 and DWELL=1.
// Expected values come from a timeline model of the channel sequence and from per-channel data tables.
module tb_mux_scan_ctrl;

  localparam int unsigned DW = 3;
  localparam int D4 = 4;
  localparam int D1 = 1;

  logic clk;
  logic rst_n;

  logic           start4, cont4;
  logic [DW-1:0]  m4;
  logic [2:0]     s4;
  logic           busy4, ovr4;
  logic [7:0][DW-1:0] tbl4;

  logic           start1, cont1;
  logic [DW-1:0]  m1;
  logic [2:0]     s1;
  logic           busy1, ovr1;
  logic [7:0][DW-1:0] tbl1;

  int checks = 0;
  int errors = 0;

  mux_scan_if #(.DATA_WIDTH(DW)) bus4 ();
  mux_scan_if #(.DATA_WIDTH(DW)) bus1 ();

  mux_scan_ctrl #(.DATA_WIDTH(DW), .DWELL(D4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start_i(start4), .continuous_i(cont4),
    .m_i(m4), .s_o(s4), .busy_o(busy4), .overrun_o(ovr4), .bus(bus4)
  );

  mux_scan_ctrl #(.DATA_WIDTH(DW), .DWELL(D1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start_i(start1), .continuous_i(cont1),
    .m_i(m1), .s_o(s1), .busy_o(busy1), .overrun_o(ovr1), .bus(bus1)
  );

  // Behavioural 5:1 mux: each channel carries a table entry
  always_comb m4 = tbl4[s4];
  always_comb m1 = tbl1[s1];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected frame: channel k's value in slot k, slot 0 at the LSB
  function automatic logic [5*DW-1:0] pack(input logic [7:0][DW-1:0] t);
    logic [5*DW-1:0] f;
    f = '0;
    for (int k = 0; k < 5; k++) f[k*DW +: DW] = t[k];
    return f;
  endfunction

  // Channel held after edge E0+t of a scan
  function automatic int exp_sel(input int t, input int dwell);
    return (t >= 5*dwell) ? 0 : t / dwell;
  endfunction

  task automatic rand_tbl4();
    tbl4 = '0;
    for (int k = 0; k < 5; k++) tbl4[k] = DW'($urandom_range(0, 7));
  endtask

  task automatic rand_tbl1();
    tbl1 = '0;
    for (int k = 0; k < 5; k++) tbl1[k] = DW'($urandom_range(0, 7));
  endtask

  logic [5*DW-1:0] exp_a, exp_b;
  int n;

  initial begin
    rst_n = 1'b0;
    start4 = 1'b0; cont4 = 1'b0; bus4.frame_ready = 1'b0; tbl4 = '0;
    start1 = 1'b0; cont1 = 1'b0; bus1.frame_ready = 1'b0; tbl1 = '0;

    // Reset state
    #2;
    chk("rst_s", 32'(s4), 0);
    chk("rst_busy", 32'(busy4), 0);
    chk("rst_frame", 32'(bus4.frame), 0);
    chk("rst_valid", 32'(bus4.frame_valid), 0);
    chk("rst_overrun", 32'(ovr4), 0);
    chk("rst_valid1", 32'(bus1.frame_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Single scan with m = s+1
    for (int k = 0; k < 5; k++) tbl4[k] = DW'(k + 1);
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    chk("s1_s_e0", 32'(s4), 0);
    chk("s1_busy_e0", 32'(busy4), 1);
    for (int t = 1; t <= 5*D4; t++) begin
      tick();
      chk("s1_sel", 32'(s4), 32'(exp_sel(t, D4)));
      chk("s1_busy", 32'(busy4), (t < 5*D4) ? 1 : 0);
      chk("s1_valid", 32'(bus4.frame_valid), (t < 5*D4) ? 0 : 1);
    end
    chk("s1_frame", 32'(bus4.frame), 32'({3'd5, 3'd4, 3'd3, 3'd2, 3'd1}));
    bus4.frame_ready = 1'b1;
    tick();
    bus4.frame_ready = 1'b0;
    chk("s1_accept", 32'(bus4.frame_valid), 0);

    // Randomized single scans with bounded wait for the frame
    for (int r = 0; r < 4; r++) begin
      rand_tbl4();
      start4 = 1'b1;
      tick();
      start4 = 1'b0;
      n = 0;
      while (bus4.frame_valid !== 1'b1 && n < 40) begin
        tick();
        n++;
      end
      chk("rnd_latency", 32'(n), 5*D4);
      chk("rnd_frame", 32'(bus4.frame), 32'(pack(tbl4)));
      bus4.frame_ready = 1'b1;
      tick();
      bus4.frame_ready = 1'b0;
      chk("rnd_accept", 32'(bus4.frame_valid), 0);
    end

    // start held through the scan: exactly one scan
    rand_tbl4();
    start4 = 1'b1;
    tick();
    for (int t = 1; t <= 5*D4; t++) begin
      tick();
      chk("hold_busy", 32'(busy4), (t < 5*D4) ? 1 : 0);
    end
    chk("hold_frame", 32'(bus4.frame), 32'(pack(tbl4)));
    start4 = 1'b0;
    tick();
    chk("hold_idle", 32'(busy4), 0);
    bus4.frame_ready = 1'b1;
    tick();
    bus4.frame_ready = 1'b0;

    // Back-pressure in continuous mode: later frames dropped, overrun set
    rand_tbl4();
    exp_a = pack(tbl4);
    cont4 = 1'b1;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    repeat (5*D4) tick();
    chk("bp_frame1", 32'(bus4.frame), 32'(exp_a));
    chk("bp_ovr1", 32'(ovr4), 0);
    for (int k = 0; k < 5; k++) tbl4[k] = 3'b111;
    repeat (5*D4) tick();
    chk("bp_ovr2", 32'(ovr4), 1);
    chk("bp_valid2", 32'(bus4.frame_valid), 1);
    chk("bp_frame2", 32'(bus4.frame), 32'(exp_a));
    chk("bp_busy2", 32'(busy4), 1);
    cont4 = 1'b0;
    repeat (5*D4) tick();
    chk("bp_busy3", 32'(busy4), 0);
    chk("bp_frame3", 32'(bus4.frame), 32'(exp_a));
    chk("bp_ovr3", 32'(ovr4), 1);
    bus4.frame_ready = 1'b1;
    tick();
    bus4.frame_ready = 1'b0;
    chk("bp_accept", 32'(bus4.frame_valid), 0);

    // Reset mid-scan, then a clean scan
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    repeat (7) tick();
    rst_n = 1'b0;
    #1;
    chk("mrst_s", 32'(s4), 0);
    chk("mrst_busy", 32'(busy4), 0);
    chk("mrst_frame", 32'(bus4.frame), 0);
    chk("mrst_valid", 32'(bus4.frame_valid), 0);
    chk("mrst_ovr", 32'(ovr4), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("mrst_idle", 32'(busy4), 0);
    rand_tbl4();
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    repeat (5*D4) tick();
    chk("mrst_valid2", 32'(bus4.frame_valid), 1);
    chk("mrst_frame2", 32'(bus4.frame), 32'(pack(tbl4)));
    bus4.frame_ready = 1'b1;
    tick();
    bus4.frame_ready = 1'b0;

    // Accept on the same edge as the next completion
    rand_tbl4();
    exp_a = pack(tbl4);
    cont4 = 1'b1;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    repeat (5*D4) tick();
    chk("sim_frame1", 32'(bus4.frame), 32'(exp_a));
    rand_tbl4();
    tbl4[0] = ~exp_a[DW-1:0];
    exp_b = pack(tbl4);
    repeat (5*D4 - 1) tick();
    bus4.frame_ready = 1'b1;
    tick();
    chk("sim_frame2", 32'(bus4.frame), 32'(exp_b));
    chk("sim_valid2", 32'(bus4.frame_valid), 1);
    chk("sim_ovr2", 32'(ovr4), 0);
    tick();
    bus4.frame_ready = 1'b0;
    cont4 = 1'b0;
    chk("sim_accept", 32'(bus4.frame_valid), 0);
    repeat (5*D4 - 1) tick();
    chk("sim_valid3", 32'(bus4.frame_valid), 1);
    chk("sim_frame3", 32'(bus4.frame), 32'(exp_b));
    chk("sim_ovr3", 32'(ovr4), 0);
    chk("sim_busy3", 32'(busy4), 0);
    bus4.frame_ready = 1'b1;
    tick();
    bus4.frame_ready = 1'b0;

    // DWELL=1: select steps every cycle
    for (int r = 0; r < 3; r++) begin
      rand_tbl1();
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      chk("d1_s_e0", 32'(s1), 0);
      for (int t = 1; t <= 5*D1; t++) begin
        tick();
        chk("d1_sel", 32'(s1), 32'(exp_sel(t, D1)));
      end
      chk("d1_valid", 32'(bus1.frame_valid), 1);
      chk("d1_busy", 32'(busy1), 0);
      chk("d1_frame", 32'(bus1.frame), 32'(pack(tbl1)));
      bus1.frame_ready = 1'b1;
      tick();
      bus1.frame_ready = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_scan_ctrl.md
# mux_scan_ctrl

Sequential scan controller that drives the 3-bit select of the 5-to-1 multiplexer (inputs u, v, w, x, y) and captures its output. It steps the select through channels 0..4, holds each channel for a programmable dwell time, and samples the mux output into a 5-slot frame. It presents the completed frame to a downstream consumer through a valid/ready handshake. It sits directly upstream of the mux, driving `s`, and directly downstream of it, consuming `m`.

## Interface
- DATA_WIDTH, 3: width of each mux channel and of `m`.
- DWELL, 4: cycles each select value is held before sampling; legal range 1..255.

- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request one scan; sampled only in IDLE.
- continuous  input  1  when 1 at scan completion, the next scan starts immediately.
- m  input  DATA_WIDTH  mux output for the currently driven select.
- s  output  3  mux select (registered); values 0..4 only.
- busy  output  1  1 while in SCAN.
- frame  output  5*DATA_WIDTH  captured frame: slot k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]; slot 0 = u (LSB).
- frame_valid  output  1  frame holds an unconsumed result.
- frame_ready  input  1  consumer accepts frame when valid and ready are both 1 at a clock edge.
- overrun  output  1  sticky; set when a frame completes while the previous one is still unconsumed.

## Operation
- Reset (asynchronous, immediate): state=IDLE, s=0, dwell counter=0, capture buffer=0, frame=0, frame_valid=0, busy=0, overrun=0.
- FSM states: IDLE, SCAN.
- IDLE: s=0. On an edge with start=1: go to SCAN, s=0, cnt=DWELL-1.
- SCAN, each edge:
  - cnt≠0: cnt decrements.
  - cnt=0: buffer slot[s] <= m.
    - s<4: s increments, cnt=DWELL-1.
    - s=4: completion.
- Completion (same edge as the slot-4 capture):
  - If frame_valid=0, or frame_ready=1 at that edge: frame <= {m, slots 3..0}, frame_valid=1.
  - Otherwise: the new frame is dropped, frame and frame_valid are unchanged, and overrun <= 1.
  - Then: if continuous=1, remain in SCAN with s=0, cnt=DWELL-1. Otherwise go to IDLE with s=0.
- Handshake: frame_valid & frame_ready at an edge with no completion clears frame_valid. frame stays stable while frame_valid=1.
- start while busy: ignored. continuous cleared mid-scan: the current scan finishes, then IDLE.
- s never takes values 5..7.
- overrun clears only on reset.
- Counter width is ceil(log2(DWELL)), minimum 1. DWELL=1 samples every cycle.

## Timing
- The edge that accepts start is E0. busy=1 and s=0 are visible after E0.
- Channel k is driven from E0+k*DWELL to E0+(k+1)*DWELL, and sampled at edge E0+(k+1)*DWELL.
- frame_valid rises after edge E0+5*DWELL (20 cycles for DWELL=4). busy falls at the same edge unless continuous=1.
- In continuous mode there are no idle cycles between scans. The frame period is 5*DWELL cycles.
- The sampled `m` must be stable combinationally within the cycle in which s is held. Since s is held for at least one full cycle, no extra pipeline stage is needed.
- Reset asserted mid-scan: outputs take reset values immediately. The partial frame is discarded. After deassertion the block waits in IDLE for start.

## Test plan
- Single scan, DWELL=4, DATA_WIDTH=3, bench drives m = s+1. Pulse start at E0. Expect frame = {3'd5,3'd4,3'd3,3'd2,3'd1} and frame_valid=1 after E0+20. Expect s to step 0,1,2,3,4 every 4 cycles, then return to 0, with busy=0.
- Back-pressure: frame_ready=0, continuous=1, m = 3'b111 on the second scan. Expect the first frame to hold unchanged, overrun=1 after E0+40, and frame_valid to remain 1.
- Simultaneous accept and completion: continuous=1, frame_ready=1 pulsed exactly at edge E0+40. Expect frame to update to the second frame, frame_valid to stay 1, and overrun=0.
- Reset mid-scan: assert rst_n=0 at E0+7. Expect s=0, busy=0, frame=0, and frame_valid=0 immediately. Then issue a new start and expect a correct full frame 20 cycles later.
- start held high during SCAN with continuous=0: expect exactly one scan, busy=0 after E0+20, and a second scan starting only on the next start seen in IDLE.
- DWELL=1: expect s to change every cycle and the frame to complete 5 cycles after start, with frame slots matching m at each sampling edge.
